hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It resolves RAW hazards by forwarding where possible and stalling only on load-use. It tracks one outstanding multi-cycle op (MAC/DIV) with a register scoreboard, and flushes on taken branches. It sits beside the ID/EX pipeline register, drives PC/IF-ID freeze, ID/EX bubble and IF/ID flush, and supplies registered forwarding selects to the EX-stage operand muxes.

## Interface
- `ADDR_W`, 5, register address width
- `NREG`, 32, architectural register count (2**ADDR_W)
- `CNT_W`, 16, stall performance counter width
- `clk` in 1, pipeline clock
- `rst_n` in 1, asynchronous active-low reset
- `rs1_id`, `rs2_id` in ADDR_W, ID-stage source registers
- `rs1_used_id`, `rs2_used_id` in 1, source actually read by ID instruction
- `rd_id` in ADDR_W, ID-stage destination
- `regwrite_id` in 1, ID instruction writes `rd_id`
- `mc_op_id` in 1, ID instruction is a multi-cycle op
- `rd_ex` in ADDR_W, EX-stage destination
- `regwrite_ex` in 1, EX instruction writes `rd_ex`
- `memread_ex` in 1, EX instruction is a load
- `mc_start_ex` in 1, EX instruction issues to MC unit this cycle (dest `rd_ex`)
- `rd_mem` in ADDR_W, MEM-stage destination
- `regwrite_mem` in 1, MEM instruction writes `rd_mem`
- `mc_done` in 1, MC unit writeback pulse
- `mc_rd` in ADDR_W, destination of completing MC op
- `branch_taken_ex` in 1, taken branch/jump resolved in EX
- `stall` out 1, freeze PC and IF/ID
- `bubble_ex` out 1, load NOP into ID/EX
- `flush_id` out 1, clear IF/ID
- `fwd_a`, `fwd_b` out 2, EX operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
- `mc_busy` out 1, an MC op is outstanding
- `stall_cnt` out CNT_W, saturating stall-cycle count

## Operation
- Match rule for a source: used, nonzero, equal to producer `rd`, producer write enable set. x0 never matches.
- The register file has write-through bypass, so a WB-stage producer never needs action.
- Load-use: `memread_ex` and EX match on rs1 or rs2. Result: `stall=1`, `bubble_ex=1`.
- Scoreboard: a `pending[NREG]` bit vector.
  - Set `pending[rd_ex]` on `mc_start_ex` when `rd_ex != 0`.
  - Clear `pending[mc_rd]` on `mc_done`.
  - When start and done hit the same register in the same cycle, set wins.
  - `mc_done` for a non-pending register is ignored.
- `mc_busy` (register):
  - Set on `mc_start_ex`, including when `rd_ex = 0`.
  - Cleared on `mc_done`.
  - Start wins over a simultaneous done.
- Scoreboard stall (also bubbles EX) when any of:
  - A used rs is pending and not being completed by `mc_done`/`mc_rd` this cycle.
  - WAW: `regwrite_id` and `pending[rd_id]`.
  - Structural: `mc_op_id` and (`mc_busy` or `mc_start_ex`).
- Branch: `branch_taken_ex` forces `flush_id=1`, `bubble_ex=1`, `stall=0`. It overrides every stall source.
- Forwarding selects are computed from the ID instruction and registered on the ID->EX advance, so they are valid while that instruction is in EX.
  - EX match gives 10 (producer is then in MEM).
  - Otherwise MEM match gives 01 (producer is then in WB).
  - EX priority over MEM.
  - On stall or bubble, the registered selects load 00.
- `stall_cnt` increments every cycle `stall=1` and saturates at all-ones.

## Timing
- `stall`, `bubble_ex` and `flush_id` are combinational, same cycle as inputs.
- `fwd_a`, `fwd_b`, `mc_busy`, `pending` and `stall_cnt` are registered, updated on the `clk` rising edge.
- Load-use costs exactly 1 stall cycle. The next cycle the load is in MEM and the consumer gets select 01 in EX.
- MC consumer stalls until the cycle `mc_done` names its register. It advances in that same cycle.
- Reset (async, any time including mid MC op) clears:
  - `pending` to 0, `mc_busy=0`
  - `fwd_a=fwd_b=00`, `stall_cnt=0`
  - The MC unit is reset by the same `rst_n`; no stale `mc_done` is expected.
- Combinational outputs at reset follow inputs, with the scoreboard at 0.

## Configuration
- `HAZARD_FWD_EN` defined:
  - Forwarding as above.
  - Only load-use and scoreboard stalls.
- Not defined:
  - `fwd_a`/`fwd_b` are held at 00.
  - Any EX or MEM match stalls and bubbles, whether or not the producer is a load.
  - Scoreboard and branch behaviour are unchanged.

## Test plan
- `add x5` in EX then `sub` using rs1=x5 in ID: `stall=0`. Next cycle `fwd_a=10`. With `HAZARD_FWD_EN` undefined: `stall=1` for 2 cycles.
- `lw x7` (`memread_ex=1`, `rd_ex=7`) with rs2=x7: `stall=1`, `bubble_ex=1` for 1 cycle. Next EX cycle `fwd_b=01`.
- Issue MC op `rd=x9`, then an ID consumer of x9: `stall=1` until `mc_done=1`, `mc_rd=9`. The consumer advances that cycle. `stall_cnt` equals the stalled cycles.
- `mc_busy=1` and a second `mc_op_id`: stall. Simultaneous `mc_start_ex` (rd=3) and `mc_done` (rd=3): `pending[3]=1`, `mc_busy=1`.
- Load-use hazard together with `branch_taken_ex=1`: `stall=0`, `flush_id=1`, `bubble_ex=1`.
- Assert `rst_n=0` mid MC op with `pending[9]=1`: all registered outputs return to 0 asynchronously, and the x9 consumer no longer stalls.

Source files
------------

// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if
//   Bundle of pipeline-side signals seen by the hazard/forwarding controller.
//   The pipeline (master) drives the ID/EX/MEM stage descriptors, the MC unit
//   completion pulse and the branch resolution; the controller (slave) drives
//   the freeze/bubble/flush controls, the registered forwarding selects, the
//   MC busy flag, the stall counter and a debug view of the MC scoreboard.
//
//   Handshake note: there is no valid/ready pair here. Every input is sampled
//   every cycle; stall/bubble_ex/flush_id are same-cycle combinational
//   responses, everything else is registered on the rising clock edge.
//
// Parameters
//   ADDR_W : register address width
//   NREG   : architectural register count (2**ADDR_W)
//   CNT_W  : stall counter width
interface hazard_fwd_unit_if #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 2 ** ADDR_W,
  parameter int CNT_W  = 16
);
  // ID stage
  logic [ADDR_W-1:0] rs1_id;
  logic [ADDR_W-1:0] rs2_id;
  logic              rs1_used_id;
  logic              rs2_used_id;
  logic [ADDR_W-1:0] rd_id;
  logic              regwrite_id;
  logic              mc_op_id;
  // EX stage
  logic [ADDR_W-1:0] rd_ex;
  logic              regwrite_ex;
  logic              memread_ex;
  logic              mc_start_ex;
  // MEM stage
  logic [ADDR_W-1:0] rd_mem;
  logic              regwrite_mem;
  // MC unit writeback
  logic              mc_done;
  logic [ADDR_W-1:0] mc_rd;
  // Branch resolution
  logic              branch_taken_ex;
  // Controller outputs
  logic              stall;
  logic              bubble_ex;
  logic              flush_id;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mc_busy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [NREG-1:0]   pending_dbg;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, regwrite_id,
           mc_op_id, rd_ex, regwrite_ex, memread_ex, mc_start_ex, rd_mem,
           regwrite_mem, mc_done, mc_rd, branch_taken_ex,
    input  stall, bubble_ex, flush_id, fwd_a, fwd_b, mc_busy, stall_cnt,
           pending_dbg
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, regwrite_id,
           mc_op_id, rd_ex, regwrite_ex, memread_ex, mc_start_ex, rd_mem,
           regwrite_mem, mc_done, mc_rd, branch_taken_ex,
    output stall, bubble_ex, flush_id, fwd_a, fwd_b, mc_busy, stall_cnt,
           pending_dbg
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard detection and forwarding control for a 5-stage RISC-V pipeline.
//   RAW hazards are resolved by forwarding where possible and by stalling on
//   load-use; one outstanding multi-cycle (MAC/DIV) op is tracked with a
//   per-register pending scoreboard; taken branches flush IF/ID and bubble EX.
//
// Ports
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : hazard_fwd_unit_if.slave
//                inputs  - ID/EX/MEM stage descriptors, mc_done/mc_rd,
//                          branch_taken_ex
//                outputs - stall, bubble_ex, flush_id (combinational),
//                          fwd_a, fwd_b, mc_busy, stall_cnt, pending_dbg
//                          (registered)
//
// Configuration
//   HAZARD_FWD_EN defined   : forwarding enabled; only load-use and
//                             scoreboard hazards stall.
//   HAZARD_FWD_EN undefined : fwd_a/fwd_b stay 00; any EX or MEM producer
//                             match stalls and bubbles.
//
// Forward select encoding: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
// The regfile writes through, so a producer in WB never needs any action.
module hazard_fwd_unit #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 2 ** ADDR_W,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst_n,
  hazard_fwd_unit_if.slave bus
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_MEM = 2'b01;

  // A source matches a producer only when it is really read, is not x0, and
  // the producer really writes that register.
  function automatic logic src_match(
    input logic              used,
    input logic [ADDR_W-1:0] rs,
    input logic [ADDR_W-1:0] rd,
    input logic              we
  );
    return used && (rs != '0) && (rs == rd) && we;
  endfunction

  // Registered state
  logic [NREG-1:0]  pending_q;
  logic [NREG-1:0]  pending_d;
  logic             mc_busy_q;
  logic [1:0]       fwd_a_q;
  logic [1:0]       fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Combinational hazard terms
  logic       ex_a, ex_b, mem_a, mem_b;
  logic       data_stall;
  logic       sb_a, sb_b, sb_waw, sb_struct, sb_stall;
  logic       hazard;
  logic       stall_o, bubble_o, flush_o;
  logic [1:0] fwd_a_d, fwd_b_d;

  always_comb begin
    ex_a  = src_match(bus.rs1_used_id, bus.rs1_id, bus.rd_ex,  bus.regwrite_ex);
    ex_b  = src_match(bus.rs2_used_id, bus.rs2_id, bus.rd_ex,  bus.regwrite_ex);
    mem_a = src_match(bus.rs1_used_id, bus.rs1_id, bus.rd_mem, bus.regwrite_mem);
    mem_b = src_match(bus.rs2_used_id, bus.rs2_id, bus.rd_mem, bus.regwrite_mem);

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time.
    data_stall = bus.memread_ex && (ex_a || ex_b);
    fwd_a_d    = ex_a ? FWD_EX : (mem_a ? FWD_MEM : FWD_RF);
    fwd_b_d    = ex_b ? FWD_EX : (mem_b ? FWD_MEM : FWD_RF);
`else
    // No bypass paths: wait until the producer reaches WB.
    data_stall = ex_a || ex_b || mem_a || mem_b;
    fwd_a_d    = FWD_RF;
    fwd_b_d    = FWD_RF;
`endif

    // A pending source is released in the very cycle mc_done names it, so
    // the consumer advances together with the MC writeback. pending[0] is
    // never set, so x0 cannot stall here.
    sb_a = bus.rs1_used_id && pending_q[bus.rs1_id] &&
           !(bus.mc_done && (bus.mc_rd == bus.rs1_id));
    sb_b = bus.rs2_used_id && pending_q[bus.rs2_id] &&
           !(bus.mc_done && (bus.mc_rd == bus.rs2_id));
    sb_waw    = bus.regwrite_id && pending_q[bus.rd_id];
    sb_struct = bus.mc_op_id && (mc_busy_q || bus.mc_start_ex);
    sb_stall  = sb_a || sb_b || sb_waw || sb_struct;

    hazard = data_stall || sb_stall;

    // A taken branch kills the ID instruction, so any stall it would have
    // caused is irrelevant; flushing takes over.
    flush_o  = bus.branch_taken_ex;
    stall_o  = hazard && !bus.branch_taken_ex;
    bubble_o = hazard || bus.branch_taken_ex;
  end

  // Scoreboard next state: clear on completion first, then set on issue so a
  // same-register start/done pair leaves the bit set. A done for a register
  // that is not pending just clears an already-clear bit.
  always_comb begin
    pending_d = pending_q;
    if (bus.mc_done) begin
      pending_d[bus.mc_rd] = 1'b0;
    end
    if (bus.mc_start_ex && (bus.rd_ex != '0)) begin
      pending_d[bus.rd_ex] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Busy covers any issued op, including one targeting x0; start wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_busy_q <= 1'b0;
    end else if (bus.mc_start_ex) begin
      mc_busy_q <= 1'b1;
    end else if (bus.mc_done) begin
      mc_busy_q <= 1'b0;
    end
  end

  // Selects follow the ID instruction into EX. When it does not advance
  // (stall) or EX receives a NOP (bubble), EX reads the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (stall_o || bubble_o) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall       = stall_o;
  assign bus.bubble_ex   = bubble_o;
  assign bus.flush_id    = flush_o;
  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;
  assign bus.mc_busy     = mc_busy_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.pending_dbg = pending_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
//   Directed vectors for hazard_fwd_unit. Each vector drives one cycle of
//   pipeline state and pushes the hand-computed outputs expected in that
//   cycle; a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_hazard_fwd_unit;

  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int CNT_W  = 16;
  localparam int EXP_W  = 3 + 2 + 2 + 1 + CNT_W + NREG;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(CNT_W)) bus ();

  hazard_fwd_unit #(.ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int vec_id   = 0;
  int mon_id   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", mon_id, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      e = exp_q.pop_front();
      check("stall",     {31'd0, bus.stall},       {31'd0, e[EXP_W-1]});
      check("bubble_ex", {31'd0, bus.bubble_ex},   {31'd0, e[EXP_W-2]});
      check("flush_id",  {31'd0, bus.flush_id},    {31'd0, e[EXP_W-3]});
      check("fwd_a",     {30'd0, bus.fwd_a},       {30'd0, e[EXP_W-4 -: 2]});
      check("fwd_b",     {30'd0, bus.fwd_b},       {30'd0, e[EXP_W-6 -: 2]});
      check("mc_busy",   {31'd0, bus.mc_busy},     {31'd0, e[EXP_W-8]});
      check("stall_cnt", {16'd0, bus.stall_cnt},   {16'd0, e[NREG +: CNT_W]});
      check("pending",   bus.pending_dbg,          e[NREG-1:0]);
      mon_id++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr();
    bus.rs1_id = '0; bus.rs2_id = '0; bus.rs1_used_id = 1'b0; bus.rs2_used_id = 1'b0;
    bus.rd_id = '0; bus.regwrite_id = 1'b0; bus.mc_op_id = 1'b0;
    bus.rd_ex = '0; bus.regwrite_ex = 1'b0; bus.memread_ex = 1'b0; bus.mc_start_ex = 1'b0;
    bus.rd_mem = '0; bus.regwrite_mem = 1'b0;
    bus.mc_done = 1'b0; bus.mc_rd = '0;
    bus.branch_taken_ex = 1'b0;
  endtask

  task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit we, input bit mc);
    bus.rs1_id = ADDR_W'(rs1); bus.rs1_used_id = u1;
    bus.rs2_id = ADDR_W'(rs2); bus.rs2_used_id = u2;
    bus.rd_id = ADDR_W'(rd); bus.regwrite_id = we; bus.mc_op_id = mc;
  endtask

  task automatic set_ex(input int rd, input bit we, input bit mr, input bit mcs);
    bus.rd_ex = ADDR_W'(rd); bus.regwrite_ex = we; bus.memread_ex = mr; bus.mc_start_ex = mcs;
  endtask

  task automatic set_mem(input int rd, input bit we);
    bus.rd_mem = ADDR_W'(rd); bus.regwrite_mem = we;
  endtask

  task automatic set_mc(input bit done, input int rd);
    bus.mc_done = done; bus.mc_rd = ADDR_W'(rd);
  endtask

  // Push this cycle's expected outputs, advance one clock, clear inputs.
  task automatic step(input bit s, input bit b, input bit f,
                      input logic [1:0] fa, input logic [1:0] fb, input bit busy,
                      input int cnt, input logic [NREG-1:0] pend);
    exp_q.push_back({s, b, f, fa, fb, busy, CNT_W'(cnt), pend});
    vec_id++;
    @(posedge clk);
    #1;
    clr();
  endtask

  // ---------------- stimulus ----------------
  localparam logic [NREG-1:0] P9 = NREG'(1) << 9;
  localparam logic [NREG-1:0] P3 = NREG'(1) << 3;

  initial begin
    int c;
    rst_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // V0: reset state
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, '0);
    // V1: add x5 in EX, sub rs1=x5 in ID
    set_ex(5, 1, 0, 0); set_id(5, 1, 6, 1, 10, 1, 0);
    step(!FWD, !FWD, 0, 2'b00, 2'b00, 0, 0, '0);
    // V2: producer x5 now in MEM, consumer still reads x5
    set_id(5, 1, 6, 1, 10, 1, 0); set_mem(5, 1);
    step(!FWD, !FWD, 0, FWD ? 2'b10 : 2'b00, 2'b00, 0, FWD ? 0 : 1, '0);
    // V3: unrelated instruction
    set_id(1, 1, 2, 1, 11, 1, 0);
    step(0, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00, 0, FWD ? 0 : 2, '0);
    // V4: same reg produced in EX and MEM, EX wins
    set_id(4, 1, 4, 1, 12, 1, 0); set_ex(4, 1, 0, 0); set_mem(4, 1);
    step(!FWD, !FWD, 0, 2'b00, 2'b00, 0, FWD ? 0 : 2, '0);
    // V5: x0 source and unused source never match
    set_id(0, 1, 8, 0, 13, 1, 0); set_ex(0, 1, 0, 0); set_mem(8, 1);
    step(0, 0, 0, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00, 0, FWD ? 0 : 3, '0);
    // V6: lw x7 in EX, rs2=x7 in ID -> load-use
    set_id(1, 1, 7, 1, 14, 1, 0); set_ex(7, 1, 1, 0);
    step(1, 1, 0, 2'b00, 2'b00, 0, FWD ? 0 : 3, '0);
    // V7: load in MEM, EX holds the bubble
    set_id(1, 1, 7, 1, 14, 1, 0); set_mem(7, 1);
    step(!FWD, !FWD, 0, 2'b00, 2'b00, 0, FWD ? 1 : 4, '0);
    // V8: consumer in EX
    step(0, 0, 0, 2'b00, FWD ? 2'b01 : 2'b00, 0, FWD ? 1 : 5, '0);
    c = FWD ? 1 : 5;
    // V9: issue MC op rd=x9
    set_ex(9, 0, 0, 1); set_id(1, 1, 2, 0, 15, 1, 0);
    step(0, 0, 0, 2'b00, 2'b00, 0, c, '0);
    // V10-V11: x9 consumer waits
    set_id(9, 1, 0, 0, 16, 1, 0);
    step(1, 1, 0, 2'b00, 2'b00, 1, c, P9);
    set_id(9, 1, 0, 0, 16, 1, 0);
    step(1, 1, 0, 2'b00, 2'b00, 1, c + 1, P9);
    // V12: mc_done names x9, consumer advances
    set_id(9, 1, 0, 0, 16, 1, 0); set_mc(1, 9);
    step(0, 0, 0, 2'b00, 2'b00, 1, c + 2, P9);
    // V13
    step(0, 0, 0, 2'b00, 2'b00, 0, c + 2, '0);
    // V14: MC op in ID while one issues (rd=x0)
    set_ex(0, 0, 0, 1); set_id(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 2'b00, 2'b00, 0, c + 2, '0);
    // V15: MC op in ID while busy
    set_id(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 2'b00, 2'b00, 1, c + 3, '0);
    // V16: x0 op completes
    set_mc(1, 0);
    step(0, 0, 0, 2'b00, 2'b00, 1, c + 4, '0);
    // V17: start and done on x3 together
    set_ex(3, 0, 0, 1); set_mc(1, 3);
    step(0, 0, 0, 2'b00, 2'b00, 0, c + 4, '0);
    // V18: WAW on pending x3
    set_id(0, 0, 0, 0, 3, 1, 0);
    step(1, 1, 0, 2'b00, 2'b00, 1, c + 4, P3);
    // V19: done for non-pending x5 leaves x3 pending
    set_mc(1, 5);
    step(0, 0, 0, 2'b00, 2'b00, 1, c + 5, P3);
    // V20: x3 completes
    set_mc(1, 3);
    step(0, 0, 0, 2'b00, 2'b00, 0, c + 5, P3);
    // V21: load-use plus taken branch
    set_ex(7, 1, 1, 0); set_id(7, 1, 0, 0, 17, 1, 0); bus.branch_taken_ex = 1'b1;
    step(0, 1, 1, 2'b00, 2'b00, 0, c + 5, '0);
    // V22
    step(0, 0, 0, 2'b00, 2'b00, 0, c + 5, '0);
    // V23-V24: MC op on x9 with a stalled consumer
    set_ex(9, 0, 0, 1); set_id(1, 1, 0, 0, 18, 1, 0);
    step(0, 0, 0, 2'b00, 2'b00, 0, c + 5, '0);
    set_id(9, 1, 0, 0, 19, 1, 0);
    step(1, 1, 0, 2'b00, 2'b00, 1, c + 5, P9);
    // V25: asynchronous reset mid op, consumer of x9 present
    rst_n = 1'b0;
    set_id(9, 1, 0, 0, 19, 1, 0);
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, '0);
    // V26: release
    rst_n = 1'b1;
    step(0, 0, 0, 2'b00, 2'b00, 0, 0, '0);

    @(negedge clk);
    mon_id = vec_id;
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
